// File: rtl/ram_32x4.sv
// ram_32x4: single-port 32-bit word memory with four byte lanes, byte strobes and 1-cycle read latency.
// Optional macro RAM_RANGE_CHECK_EN: out-of-range accesses read as zero and drop writes. Rev 1.0
`default_nettype none

module ram_32x4 #(
  parameter logic [31:0] BASE_ADDRESSE = 32'd0,
  parameter int          SIZE          = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_v,
  input  logic        w_v,
  input  logic [31:0] adr,
  input  logic [31:0] data,
  input  logic [3:0]  strobe,
  output logic [31:0] resp,
  output logic        ack
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [31:0]   mem [SIZE];

  logic [31:0]   offset;
  logic [31:0]   word;
  logic [AW-1:0] idx;
  logic          hit;
  logic [31:0]   cur_word;
  logic [31:0]   merged;
  logic          unused_bits;

  // Subtraction wraps, so addresses below the base land far above SIZE.
  assign offset = adr - BASE_ADDRESSE;
  assign word   = {2'b00, offset[31:2]};
  assign idx    = word[AW-1:0];

`ifdef RAM_RANGE_CHECK_EN
  assign hit = (word < 32'(SIZE));
`else
  assign hit = 1'b1;
`endif

  assign unused_bits = ^{offset[1:0], word};

  assign cur_word = mem[idx];

  always_comb begin
    merged = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (strobe[k]) begin
        merged[8*k +: 8] = data[8*k +: 8];
      end
    end
  end

  // Storage has no reset so contents preloaded from outside survive rst_n.
  always @(posedge clk) begin
    if (w_v && hit) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp <= 32'h0;
      ack  <= 1'b0;
    end else begin
      ack <= r_v | w_v;
      if (r_v) begin
        resp <= hit ? cur_word : 32'h0;
      end
    end
  end

`ifdef RAM_RANGE_CHECK_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (r_v || w_v) && !hit) begin
      $display("ram_32x4 warning: out-of-range access at adr %h", adr);
    end
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_32x4.sv
// tb_ram_32x4: directed vector table plus randomized traffic checked against a behavioural memory model.
`default_nettype none

module tb_ram_32x4;

  localparam logic [31:0] BASE = 32'd10000;
  localparam int          SIZE = 16;
`ifdef RAM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        r_v;
  logic        w_v;
  logic [31:0] adr;
  logic [31:0] data;
  logic [3:0]  strobe;
  logic [31:0] resp;
  logic        ack;

  ram_32x4 #(.BASE_ADDRESSE(BASE), .SIZE(SIZE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .r_v    (r_v),
    .w_v    (w_v),
    .adr    (adr),
    .data   (data),
    .strobe (strobe),
    .resp   (resp),
    .ack    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r_v;
    logic        w_v;
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic [31:0] exp_resp;
    logic        exp_ack;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] model [SIZE];
  logic [31:0] exp_resp;
  logic        exp_ack;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: word index = (adr-BASE)/4 in 32-bit arithmetic; either bounded or taken mod SIZE.
  task automatic model_access(input logic rv, input logic wv, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    bit          in_range;
    int          i;
    w        = (a - BASE) / 4;
    in_range = CHK ? (w < SIZE) : 1'b1;
    i        = int'(w % SIZE);
    exp_ack  = rv | wv;
    if (rv) exp_resp = in_range ? model[i] : 32'h0;
    if (wv && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
      end
    end
  endtask

  task automatic drive(input logic rv, input logic wv, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    r_v = rv; w_v = wv; adr = a; data = d; strobe = s;
    model_access(rv, wv, a, d, s);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rv, input logic wv, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] er, input logic ea);
    vec_t v;
    v.r_v = rv; v.w_v = wv; v.adr = a; v.data = d; v.strobe = s;
    v.exp_resp = er; v.exp_ack = ea;
    return v;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] alias_adr;
    n_checks = 0;
    n_fail   = 0;
    alias_adr = BASE + 32'(4 * SIZE);

    vecs[0]  = mk(1, 0, BASE + 12, 32'h0,        4'h0, 32'hDEADBEEF, 1);
    vecs[1]  = mk(1, 0, BASE + 13, 32'h0,        4'h0, 32'hDEADBEEF, 1);
    vecs[2]  = mk(0, 0, BASE + 0,  32'h0,        4'h0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(0, 1, BASE + 0,  32'hAABBCCDD, 4'b0101, 32'hDEADBEEF, 1);
    vecs[4]  = mk(1, 0, BASE + 0,  32'h0,        4'h0, 32'h11BB33DD, 1);
    vecs[5]  = mk(0, 1, BASE + 0,  32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, 1);
    vecs[6]  = mk(1, 0, BASE + 0,  32'h0,        4'h0, 32'h11BB33DD, 1);
    vecs[7]  = mk(1, 1, BASE + 20, 32'h2,        4'hF, 32'h1, 1);
    vecs[8]  = mk(1, 0, BASE + 20, 32'h0,        4'h0, 32'h2, 1);
    vecs[9]  = mk(1, 0, BASE + 0,  32'h0,        4'h0, 32'h11BB33DD, 1);
    vecs[10] = mk(1, 0, BASE + 4,  32'h0,        4'h0, 32'hA1A1A1A1, 1);
    vecs[11] = mk(1, 0, BASE + 8,  32'h0,        4'h0, 32'hB2B2B2B2, 1);
    vecs[12] = mk(0, 0, BASE + 8,  32'h0,        4'h0, 32'hB2B2B2B2, 0);
    vecs[13] = mk(1, 0, alias_adr, 32'h0,        4'h0, CHK ? 32'h0 : 32'h11BB33DD, 1);
    vecs[14] = mk(0, 1, alias_adr, 32'h5A5A5A5A, 4'hF, CHK ? 32'h0 : 32'h11BB33DD, 1);
    vecs[15] = mk(1, 0, BASE + 0,  32'h0,        4'h0, CHK ? 32'h11BB33DD : 32'h5A5A5A5A, 1);

    rst_n = 1'b1; r_v = 1'b0; w_v = 1'b0; adr = '0; data = '0; strobe = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_resp", resp, 32'h0);
    check("reset_ack", {31'b0, ack}, 32'h0);
    exp_resp = 32'h0;
    exp_ack  = 1'b0;

    for (int i = 0; i < SIZE; i++) model[i] = $urandom;
    model[0] = 32'h11223344;
    model[1] = 32'hA1A1A1A1;
    model[2] = 32'hB2B2B2B2;
    model[3] = 32'hDEADBEEF;
    model[5] = 32'h00000001;
    for (int i = 0; i < SIZE; i++) dut.mem[i] = model[i];

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r_v, vecs[i].w_v, vecs[i].adr, vecs[i].data, vecs[i].strobe);
      check($sformatf("vec%0d_resp", i), resp, vecs[i].exp_resp);
      check($sformatf("vec%0d_ack", i), {31'b0, ack}, {31'b0, vecs[i].exp_ack});
    end

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      else a = BASE + 32'(4 * $urandom_range(0, 2 * SIZE - 1)) + 32'($urandom_range(0, 3));
      drive(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
      check("rand_resp", resp, exp_resp);
      check("rand_ack", {31'b0, ack}, {31'b0, exp_ack});
    end

    // Reset asserted mid-read, held across an edge, then a preloaded-area word read back.
    drive(1, 0, BASE + 12, 32'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_resp", resp, 32'h0);
    check("midrst_ack", {31'b0, ack}, 32'h0);
    @(posedge clk);
    #1;
    check("rsthold_resp", resp, 32'h0);
    check("rsthold_ack", {31'b0, ack}, 32'h0);
    exp_resp = 32'h0;
    exp_ack  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, BASE + 12, 32'h0, 4'h0);
    check("postrst_resp", resp, exp_resp);
    check("postrst_ack", {31'b0, ack}, 32'h1);
    drive(0, 0, BASE, 32'h0, 4'h0);
    check("idle_ack", {31'b0, ack}, 32'h0);
    check("idle_hold", resp, exp_resp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
